core_timer_mc_regs: RTL and testbench

//  Multi-channel successor to the single-compare core timer register block. It sits behind
//  axi_slave on the ip_* register bus.
//  - One shared 64-bit mtime with a programmable prescaler.
//  - NUM_CH 64-bit comparators, each in one-shot or periodic auto-reload mode.
//  - Per-channel W1C status, enable mask, level interrupts and an OR'd core interrupt.

---
 rtl/core_timer_mc_regs.sv | 184 ++++++++++++++++++
 tb/tb_core_timer_mc_regs.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_timer_mc_regs.sv
// Multi-channel core timer register block on the ip_* register bus.
// A shared 64-bit mtime advances on prescaler ticks. Each of NUM_CH 64-bit comparators
// raises a W1C status bit when mtime >= CMP. In periodic mode the comparator auto-reloads
// by adding PERIOD.
module core_timer_mc_regs #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned PRESC_W = 16
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [15:0]       addr,
  input  logic              valid_reg_write,
  input  logic              valid_reg_read,
  input  logic [31:0]       write_data,
  input  logic [3:0]        byte_strobe,
  output logic [31:0]       read_data,
  output logic              read_data_valid,
  input  logic              debug_halt,
  output logic [NUM_CH-1:0] timer_int,
  output logic              core_timer_int
);

  localparam logic [15:0] AddrMtimeLo = 16'h000;
  localparam logic [15:0] AddrMtimeHi = 16'h004;
  localparam logic [15:0] AddrCtrl    = 16'h008;
  localparam logic [15:0] AddrPresc   = 16'h00C;
  localparam logic [15:0] AddrIntStat = 16'h010;
  localparam logic [15:0] AddrIntEn   = 16'h014;

  logic [63:0]        r_mtime;
  logic               r_en;
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] r_presc_cnt;
  logic [NUM_CH-1:0]  r_int_stat;
  logic [NUM_CH-1:0]  r_int_en;
  logic [63:0]        r_cmp      [NUM_CH];
  logic [NUM_CH-1:0]  r_periodic;
  logic [31:0]        r_period   [NUM_CH];
  logic [31:0]        r_shadow_hi;

  logic [31:0]        w_wmask;
  logic [15:0]        w_waddr;
  logic               w_ch_hit;
  logic [31:0]        w_ch_sel;
  logic [1:0]         w_ch_fld;
  logic               w_unused;
  logic               w_tick;
  logic [PRESC_W-1:0] w_presc_cnt_d;
  logic [31:0]        w_presc_wr;
  logic [63:0]        w_mtime_d;
  logic [NUM_CH-1:0]  w_match;
  logic [NUM_CH-1:0]  w_w1c;
  logic [63:0]        w_cmp_d    [NUM_CH];
  logic [31:0]        w_rdata;

  // Replace only the byte lanes enabled by the strobe
  function automatic logic [31:0] f_merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                          input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign w_waddr  = {addr[15:2], 2'b00};
  assign w_ch_hit = (addr[15:7] == 9'h002) && ({29'd0, addr[6:4]} < NUM_CH);
  assign w_ch_sel = {29'd0, addr[6:4]};
  assign w_ch_fld = addr[3:2];
  assign w_unused = ^addr[1:0];

  // Byte-lane write mask
  always_comb begin
    for (int b = 0; b < 4; b++) w_wmask[8*b +: 8] = {8{byte_strobe[b]}};
  end

  // Prescaler, mtime and comparator next-state; bus writes override tick and reload
  always_comb begin
    w_tick        = r_en && !debug_halt && (r_presc_cnt == r_presc);
    w_presc_cnt_d = r_presc_cnt;
    if (!r_en) w_presc_cnt_d = '0;
    else if (!debug_halt) w_presc_cnt_d = w_tick ? '0 : r_presc_cnt + PRESC_W'(1);

    w_presc_wr = f_merge(32'(r_presc), write_data, w_wmask);

    w_mtime_d = r_mtime;
    if (valid_reg_write && w_waddr == AddrMtimeLo) begin
      w_mtime_d[31:0] = f_merge(r_mtime[31:0], write_data, w_wmask);
    end else if (valid_reg_write && w_waddr == AddrMtimeHi) begin
      w_mtime_d[63:32] = f_merge(r_mtime[63:32], write_data, w_wmask);
    end else if (w_tick) begin
      w_mtime_d = r_mtime + 64'd1;
    end

    w_w1c = '0;
    if (valid_reg_write && w_waddr == AddrIntStat) w_w1c = write_data[NUM_CH-1:0] &
                                                            w_wmask[NUM_CH-1:0];

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_match[c] = (r_mtime >= r_cmp[c]);
      w_cmp_d[c] = r_cmp[c];
      if (valid_reg_write && w_ch_hit && w_ch_sel == c && w_ch_fld == 2'd0) begin
        w_cmp_d[c][31:0] = f_merge(r_cmp[c][31:0], write_data, w_wmask);
      end else if (valid_reg_write && w_ch_hit && w_ch_sel == c && w_ch_fld == 2'd1) begin
        w_cmp_d[c][63:32] = f_merge(r_cmp[c][63:32], write_data, w_wmask);
      end else if (w_match[c] && r_periodic[c]) begin
        w_cmp_d[c] = r_cmp[c] + {32'd0, r_period[c]};
      end
    end
  end

  // Read data mux; unmapped addresses return zero
  always_comb begin
    w_rdata = '0;
    case (w_waddr)
      AddrMtimeLo: w_rdata = r_mtime[31:0];
      AddrMtimeHi: w_rdata = r_shadow_hi;
      AddrCtrl:    w_rdata = {31'd0, r_en};
      AddrPresc:   w_rdata = 32'(r_presc);
      AddrIntStat: w_rdata = 32'(r_int_stat);
      AddrIntEn:   w_rdata = 32'(r_int_en);
      default:     ;
    endcase
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (w_ch_hit && w_ch_sel == c) begin
        case (w_ch_fld)
          2'd0:    w_rdata = r_cmp[c][31:0];
          2'd1:    w_rdata = r_cmp[c][63:32];
          2'd2:    w_rdata = {31'd0, r_periodic[c]};
          default: w_rdata = r_period[c];
        endcase
      end
    end
  end

  // Register state, bus writes and registered outputs
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_mtime         <= '0;
      r_en            <= 1'b0;
      r_presc         <= '0;
      r_presc_cnt     <= '0;
      r_int_stat      <= '0;
      r_int_en        <= '0;
      r_periodic      <= '0;
      r_shadow_hi     <= '0;
      read_data       <= '0;
      read_data_valid <= 1'b0;
      timer_int       <= '0;
      core_timer_int  <= 1'b0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_cmp[c]    <= '1;
        r_period[c] <= '0;
      end
    end else begin
      r_mtime     <= w_mtime_d;
      r_presc_cnt <= w_presc_cnt_d;
      // A match in the same cycle as a W1C keeps the bit set
      r_int_stat  <= (r_int_stat & ~w_w1c) | w_match;
      for (int unsigned c = 0; c < NUM_CH; c++) r_cmp[c] <= w_cmp_d[c];

      if (valid_reg_write) begin
        if (w_waddr == AddrCtrl && byte_strobe[0]) r_en <= write_data[0];
        if (w_waddr == AddrPresc) r_presc <= w_presc_wr[PRESC_W-1:0];
        if (w_waddr == AddrIntEn && byte_strobe[0]) r_int_en <= write_data[NUM_CH-1:0];
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          if (w_ch_hit && w_ch_sel == c && w_ch_fld == 2'd2 && byte_strobe[0]) begin
            r_periodic[c] <= write_data[0];
          end
          if (w_ch_hit && w_ch_sel == c && w_ch_fld == 2'd3) begin
            r_period[c] <= f_merge(r_period[c], write_data, w_wmask);
          end
        end
      end

      read_data_valid <= valid_reg_read;
      if (valid_reg_read) begin
        read_data <= w_rdata;
        // Snapshot the upper half so a following MTIME_HI read is coherent with MTIME_LO
        if (w_waddr == AddrMtimeLo) r_shadow_hi <= r_mtime[63:32];
      end

      timer_int      <= r_int_stat & r_int_en;
      core_timer_int <= |(r_int_stat & r_int_en);
    end
  end

endmodule

// File: tb/tb_core_timer_mc_regs.sv
// Self-checking bench for core_timer_mc_regs: directed scenarios plus randomized bus traffic
// compared cycle by cycle against a behavioural model of the register block.
module tb_core_timer_mc_regs;

  localparam int NUM_CH  = 4;
  localparam int PRESC_W = 16;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [15:0] addr;
  logic        valid_reg_write;
  logic        valid_reg_read;
  logic [31:0] write_data;
  logic [3:0]  byte_strobe;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        debug_halt;
  logic [NUM_CH-1:0] timer_int;
  logic        core_timer_int;

  core_timer_mc_regs #(.NUM_CH(NUM_CH), .PRESC_W(PRESC_W)) dut (
    .ACLK            (ACLK),
    .ARESETn         (ARESETn),
    .addr            (addr),
    .valid_reg_write (valid_reg_write),
    .valid_reg_read  (valid_reg_read),
    .write_data      (write_data),
    .byte_strobe     (byte_strobe),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .debug_halt      (debug_halt),
    .timer_int       (timer_int),
    .core_timer_int  (core_timer_int)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_mtime;
  logic        m_en;
  logic [15:0] m_presc, m_pcnt;
  logic [3:0]  m_stat, m_ien;
  logic [63:0] m_cmp [NUM_CH];
  logic        m_per [NUM_CH];
  logic [31:0] m_period [NUM_CH];
  logic [31:0] m_shadow, m_rdata;
  logic        m_rvalid;
  logic [3:0]  m_tint;
  logic        m_cint;

  task automatic model_reset();
    m_mtime = '0; m_en = 0; m_presc = '0; m_pcnt = '0; m_stat = '0; m_ien = '0;
    m_shadow = '0; m_rdata = '0; m_rvalid = 0; m_tint = '0; m_cint = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cmp[c] = '1; m_per[c] = 0; m_period[c] = '0;
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n,
                                      input logic [31:0] mk);
    return (o & ~mk) | (n & mk);
  endfunction

  function automatic logic [31:0] model_read(input logic [15:0] wa);
    logic [31:0] v;
    int ch;
    v = '0;
    case (wa)
      16'h000: v = m_mtime[31:0];
      16'h004: v = m_shadow;
      16'h008: v = {31'd0, m_en};
      16'h00C: v = {16'd0, m_presc};
      16'h010: v = {28'd0, m_stat};
      16'h014: v = {28'd0, m_ien};
      default: begin
        if (wa >= 16'h100 && int'(wa) < 'h100 + 16 * NUM_CH) begin
          ch = (int'(wa) - 'h100) / 16;
          case (int'(wa) % 16)
            0:       v = m_cmp[ch][31:0];
            4:       v = m_cmp[ch][63:32];
            8:       v = {31'd0, m_per[ch]};
            default: v = m_period[ch];
          endcase
        end
      end
    endcase
    return v;
  endfunction

  // Advance the model by one clock with the given bus inputs
  task automatic model_step(input logic wr, input logic rd, input logic [15:0] a,
                            input logic [31:0] wd, input logic [3:0] bs, input logic hl);
    logic [15:0] wa;
    logic [31:0] mk, t;
    logic [3:0]  hit, clr;
    logic        tick;
    int          base;
    wa = {a[15:2], 2'b00};
    mk = {{8{bs[3]}}, {8{bs[2]}}, {8{bs[1]}}, {8{bs[0]}}};
    m_tint   = m_stat & m_ien;
    m_cint   = |(m_stat & m_ien);
    m_rvalid = rd;
    if (rd) begin
      m_rdata = model_read(wa);
      if (wa == 16'h000) m_shadow = m_mtime[63:32];
    end
    for (int c = 0; c < NUM_CH; c++) hit[c] = (m_mtime >= m_cmp[c]);
    tick = 0;
    if (!m_en) m_pcnt = '0;
    else if (!hl) begin
      if (m_pcnt == m_presc) begin m_pcnt = '0; tick = 1; end
      else m_pcnt = m_pcnt + 16'd1;
    end
    if (wr && wa == 16'h000)      m_mtime[31:0]  = mrg(m_mtime[31:0], wd, mk);
    else if (wr && wa == 16'h004) m_mtime[63:32] = mrg(m_mtime[63:32], wd, mk);
    else if (tick)                m_mtime = m_mtime + 64'd1;
    for (int c = 0; c < NUM_CH; c++) begin
      base = 'h100 + 16 * c;
      if (wr && int'(wa) == base)          m_cmp[c][31:0]  = mrg(m_cmp[c][31:0], wd, mk);
      else if (wr && int'(wa) == base + 4) m_cmp[c][63:32] = mrg(m_cmp[c][63:32], wd, mk);
      else if (hit[c] && m_per[c])         m_cmp[c] = m_cmp[c] + {32'd0, m_period[c]};
      if (wr && int'(wa) == base + 8 && bs[0]) m_per[c] = wd[0];
      if (wr && int'(wa) == base + 12) m_period[c] = mrg(m_period[c], wd, mk);
    end
    t = wd & mk;
    clr = (wr && wa == 16'h010) ? t[3:0] : 4'd0;
    m_stat = (m_stat & ~clr) | hit;
    if (wr && wa == 16'h008 && bs[0]) m_en = wd[0];
    if (wr && wa == 16'h00C) begin
      t = mrg({16'd0, m_presc}, wd, mk);
      m_presc = t[15:0];
    end
    if (wr && wa == 16'h014 && bs[0]) m_ien = wd[3:0];
  endtask

  // ---------------- bus helpers ----------------
  task automatic step(input logic wr, input logic rd, input logic [15:0] a,
                      input logic [31:0] wd, input logic [3:0] bs);
    valid_reg_write = wr; valid_reg_read = rd; addr = a; write_data = wd; byte_strobe = bs;
    model_step(wr, rd, a, wd, bs, debug_halt);
    @(posedge ACLK); #1;
    valid_reg_write = 0; valid_reg_read = 0;
    check_eq("rvalid", {63'd0, read_data_valid}, {63'd0, m_rvalid});
    if (m_rvalid) check_eq($sformatf("rdata@%0h", a), {32'd0, read_data}, {32'd0, m_rdata});
    check_eq("timer_int", {60'd0, timer_int}, {60'd0, m_tint});
    check_eq("core_int", {63'd0, core_timer_int}, {63'd0, m_cint});
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, a, d, 4'hF);
  endtask

  task automatic rd(input logic [15:0] a, output logic [31:0] d);
    step(1'b0, 1'b1, a, 32'd0, 4'h0);
    d = read_data;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 32'd0, 4'h0);
  endtask

  logic [15:0] reset_addr [13] = '{16'h000, 16'h004, 16'h008, 16'h00C, 16'h010, 16'h014,
                                   16'h100, 16'h104, 16'h108, 16'h10C, 16'h134, 16'h140,
                                   16'h018};
  logic [31:0] reset_exp  [13] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                                   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                   32'd0, 32'd0};
  logic [15:0] rnd_addr   [12] = '{16'h000, 16'h004, 16'h008, 16'h00C, 16'h010, 16'h014,
                                   16'h100, 16'h114, 16'h128, 16'h13C, 16'h140, 16'h200};
  logic [15:0] bad_addr   [5]  = '{16'h018, 16'h140, 16'h200, 16'h0FC, 16'h14C};

  initial begin
    logic [31:0] d, d2;
    int          rise [3];
    int          nrise;
    logic        prev;
    int          r, ch;
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0]  bs;

    ARESETn = 0; addr = '0; valid_reg_write = 0; valid_reg_read = 0; write_data = '0;
    byte_strobe = '0; debug_halt = 0;
    model_reset();
    #2;
    check_eq("rst_rdata", {32'd0, read_data}, 64'd0);
    check_eq("rst_rvalid", {63'd0, read_data_valid}, 64'd0);
    check_eq("rst_tint", {60'd0, timer_int}, 64'd0);
    check_eq("rst_cint", {63'd0, core_timer_int}, 64'd0);
    #20;
    @(negedge ACLK); ARESETn = 1;

    // Reset values of all registers
    for (int i = 0; i < 13; i++) begin
      rd(reset_addr[i], d);
      check_eq($sformatf("reset_reg@%0h", reset_addr[i]), {32'd0, d}, {32'd0, reset_exp[i]});
    end

    // Prescaler 3 -> one tick every 4 cycles; debug_halt freezes
    wr(16'h00C, 32'd3);
    wr(16'h008, 32'd1);
    idle(40);
    rd(16'h000, d);
    check_eq("presc_mtime_10", {63'd0, (d >= 9 && d <= 11)}, 64'd1);
    debug_halt = 1;
    rd(16'h000, d);
    idle(8);
    rd(16'h000, d2);
    check_eq("halt_frozen", {32'd0, d2}, {32'd0, d});
    debug_halt = 0;

    // 64-bit wrap
    wr(16'h008, 32'd0);
    wr(16'h004, 32'hFFFF_FFFF);
    wr(16'h000, 32'hFFFF_FFFE);
    wr(16'h00C, 32'd0);
    wr(16'h008, 32'd1);
    idle(2);
    wr(16'h008, 32'd0);
    rd(16'h000, d);
    check_eq("wrap_lo", {32'd0, d}, 64'd1);
    rd(16'h004, d);
    check_eq("wrap_hi", {32'd0, d}, 64'd0);

    // Coherent LO/HI read across a carry
    wr(16'h004, 32'd5);
    wr(16'h000, 32'hFFFF_FFFD);
    wr(16'h008, 32'd1);
    rd(16'h000, d);
    check_eq("carry_lo", {32'd0, d}, 64'hFFFF_FFFD);
    idle(2);
    rd(16'h004, d);
    check_eq("carry_hi_snapshot", {32'd0, d}, 64'd5);
    rd(16'h000, d);
    check_eq("carry_lo2", {32'd0, d}, 64'd1);
    rd(16'h004, d);
    check_eq("carry_hi2", {32'd0, d}, 64'd6);
    wr(16'h008, 32'd0);

    // Periodic channel 1: CMP=20, PERIOD=10
    wr(16'h000, 32'd0);
    wr(16'h004, 32'd0);
    wr(16'h110, 32'd20);
    wr(16'h114, 32'd0);
    wr(16'h118, 32'd1);
    wr(16'h11C, 32'd10);
    wr(16'h010, 32'hF);
    wr(16'h014, 32'd2);
    wr(16'h008, 32'd1);
    nrise = 0; prev = 0;
    for (int i = 0; i < 3; i++) rise[i] = -1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      if (timer_int[1]) step(1'b1, 1'b0, 16'h010, 32'h2, 4'hF);
      else idle(1);
      if (timer_int[1] && !prev && nrise < 3) begin rise[nrise] = cyc; nrise++; end
      prev = timer_int[1];
      check_eq("ch0_quiet", {63'd0, timer_int[0]}, 64'd0);
    end
    check_eq("per_rise0", 64'(rise[0]), 64'd22);
    check_eq("per_gap1", 64'(rise[1] - rise[0]), 64'd10);
    check_eq("per_gap2", 64'(rise[2] - rise[1]), 64'd10);
    wr(16'h008, 32'd0);
    wr(16'h114, 32'hFFFF_FFFF);
    wr(16'h118, 32'd0);
    wr(16'h014, 32'd0);
    wr(16'h010, 32'hF);

    // One-shot channel 0: set beats clear while matching
    wr(16'h000, 32'd10);
    wr(16'h004, 32'd0);
    wr(16'h014, 32'd1);
    wr(16'h100, 32'd5);
    wr(16'h104, 32'd0);
    idle(2);
    wr(16'h010, 32'd1);
    rd(16'h010, d);
    check_eq("set_beats_w1c", {32'd0, d}, 64'd1);
    check_eq("oneshot_core", {63'd0, core_timer_int}, 64'd1);
    wr(16'h104, 32'hFFFF_FFFF);
    wr(16'h100, 32'hFFFF_FFFF);
    wr(16'h010, 32'd1);
    rd(16'h010, d);
    check_eq("w1c_clears", {32'd0, d}, 64'd0);

    // Asynchronous reset mid-read with the interrupt asserted
    wr(16'h100, 32'd5);
    wr(16'h104, 32'd0);
    idle(3);
    check_eq("pre_rst_core", {63'd0, core_timer_int}, 64'd1);
    rd(16'h000, d);
    check_eq("pre_rst_rdata", {32'd0, d}, 64'd10);
    valid_reg_read = 1; addr = 16'h000;
    #3 ARESETn = 0;
    #1;
    check_eq("arst_rdata", {32'd0, read_data}, 64'd0);
    check_eq("arst_rvalid", {63'd0, read_data_valid}, 64'd0);
    check_eq("arst_tint", {60'd0, timer_int}, 64'd0);
    check_eq("arst_cint", {63'd0, core_timer_int}, 64'd0);
    valid_reg_read = 0;
    model_reset();
    @(posedge ACLK);
    @(negedge ACLK); ARESETn = 1;
    idle(1);
    check_eq("post_rst_rvalid", {63'd0, read_data_valid}, 64'd0);
    idle(2);

    // Randomized traffic against the model
    wr(16'h00C, $urandom_range(0, 2));
    wr(16'h014, $urandom_range(0, 15));
    wr(16'h008, 32'd1);
    for (int i = 0; i < 1500; i++) begin
      debug_halt = ($urandom_range(0, 9) == 0);
      r  = $urandom_range(0, 99);
      ch = $urandom_range(0, NUM_CH - 1);
      bs = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      if (r < 40) begin
        idle(1);
      end else if (r < 60) begin
        rd(rnd_addr[$urandom_range(0, 11)], d);
      end else begin
        a = 16'h0; wd = $urandom;
        case ($urandom_range(0, 9))
          0: a = 16'h010;
          1: a = 16'h014;
          2: begin a = 16'(16'h100 + 16 * ch); wd = m_mtime[31:0] + $urandom_range(0, 40); end
          3: begin
            a  = 16'(16'h104 + 16 * ch);
            wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : m_mtime[63:32];
          end
          4: a = 16'(16'h108 + 16 * ch);
          5: begin a = 16'(16'h10C + 16 * ch); wd = $urandom_range(0, 12); end
          6: begin a = 16'h000; wd = $urandom_range(0, 100); end
          7: begin a = 16'h004; wd = 32'd0; end
          8: a = bad_addr[$urandom_range(0, 4)];
          default: begin a = 16'h008; wd = ($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0; end
        endcase
        step(1'b1, 1'b0, a, wd, bs);
      end
    end
    debug_halt = 0;
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
